// File: rtl/integration_scheduler_pkg.sv
// Shared types and helpers for the correlator integration scheduler.
// State encoding, default widths and lag-field packing.
package integration_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INTEGRATE,
        ST_SNAP,
        ST_STEP
    } state_e;

    localparam int LAG_WIDTH_DEF  = 12;
    localparam int LEN_WIDTH_DEF  = 24;
    localparam int CFG_LINE_WIDTH = 8;

    // Bit position of line a inside a packed lag bus.
    function automatic int lag_lsb(input int line, input int width);
        return line * width;
    endfunction

endpackage

// File: rtl/integration_scheduler_lag_stepper.sv
// Per-line lag offset holder: base, scan flags and live auto/cross offsets.
// Steps or wraps the live offsets on request and reports a wrap.
module lag_stepper #(
    parameter int LAG_WIDTH = 12,
    parameter int MAX_AUTO  = 1,
    parameter int MAX_CROSS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic                 cfg_live_i,
    input  logic [LAG_WIDTH-1:0] auto_base_i,
    input  logic [LAG_WIDTH-1:0] cross_base_i,
    input  logic                 scan_auto_i,
    input  logic                 scan_cross_i,
    input  logic                 step_i,
    output logic [LAG_WIDTH-1:0] auto_lag_o,
    output logic [LAG_WIDTH-1:0] cross_lag_o,
    output logic                 wrap_o
);

    localparam logic [LAG_WIDTH-1:0] AUTO_TOP  = LAG_WIDTH'(MAX_AUTO - 1);
    localparam logic [LAG_WIDTH-1:0] CROSS_TOP = LAG_WIDTH'(MAX_CROSS - 1);

    logic [LAG_WIDTH-1:0] auto_base_q, auto_base_d;
    logic [LAG_WIDTH-1:0] cross_base_q, cross_base_d;
    logic                 scan_auto_q, scan_auto_d;
    logic                 scan_cross_q, scan_cross_d;
    logic [LAG_WIDTH-1:0] auto_q, auto_d;
    logic [LAG_WIDTH-1:0] cross_q, cross_d;
    logic [LAG_WIDTH-1:0] auto_clamp, cross_clamp;
    logic                 auto_wrap, cross_wrap;

    // Clamp new bases, then pick next live offsets: compare before +1 so it never overflows.
    always_comb begin
        auto_clamp   = (auto_base_i > AUTO_TOP) ? AUTO_TOP : auto_base_i;
        cross_clamp  = (cross_base_i > CROSS_TOP) ? CROSS_TOP : cross_base_i;
        auto_wrap    = scan_auto_q && (auto_q >= AUTO_TOP);
        cross_wrap   = scan_cross_q && (cross_q >= CROSS_TOP);
        auto_base_d  = auto_base_q;
        cross_base_d = cross_base_q;
        scan_auto_d  = scan_auto_q;
        scan_cross_d = scan_cross_q;
        auto_d       = auto_q;
        cross_d      = cross_q;
        if (step_i && scan_auto_q) begin
            auto_d = auto_wrap ? auto_base_q : auto_q + 1'b1;
        end
        if (step_i && scan_cross_q) begin
            cross_d = cross_wrap ? cross_base_q : cross_q + 1'b1;
        end
        if (cfg_we_i) begin
            auto_base_d  = auto_clamp;
            cross_base_d = cross_clamp;
            scan_auto_d  = scan_auto_i;
            scan_cross_d = scan_cross_i;
            if (cfg_live_i) begin
                auto_d  = auto_clamp;
                cross_d = cross_clamp;
            end
        end
    end

    // Configuration and live offset registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            auto_base_q  <= '0;
            cross_base_q <= '0;
            scan_auto_q  <= 1'b0;
            scan_cross_q <= 1'b0;
            auto_q       <= '0;
            cross_q      <= '0;
        end else begin
            auto_base_q  <= auto_base_d;
            cross_base_q <= cross_base_d;
            scan_auto_q  <= scan_auto_d;
            scan_cross_q <= scan_cross_d;
            auto_q       <= auto_d;
            cross_q      <= cross_d;
        end
    end

    assign auto_lag_o  = auto_q;
    assign cross_lag_o = cross_q;
    assign wrap_o      = step_i && (auto_wrap || cross_wrap);

endmodule

// File: rtl/integration_scheduler.sv
// Integration cycle sequencer for the correlator counter bank:
// clear, integrate N ticks, snapshot handshake, then step lag offsets.
module integration_scheduler
    import integration_scheduler_pkg::*;
#(
    parameter int NUM_INPUTS    = 8,
    parameter int LAG_WIDTH     = LAG_WIDTH_DEF,
    parameter int MAX_LAG_AUTO  = 1,
    parameter int MAX_LAG_CROSS = 1,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF
) (
    input  logic                            sysclk,
    input  logic                            reset_n,
    input  logic                            tick,
    input  logic                            start,
    input  logic                            continuous,
    input  logic [LEN_WIDTH-1:0]            int_len,
    input  logic                            cfg_load,
    input  logic [CFG_LINE_WIDTH-1:0]       cfg_line,
    input  logic [LAG_WIDTH-1:0]            auto_base,
    input  logic [LAG_WIDTH-1:0]            cross_base,
    input  logic                            scan_auto,
    input  logic                            scan_cross,
    input  logic                            snapshot_ack,
    output logic                            counters_clear,
    output logic                            counters_enable,
    output logic                            snapshot_req,
    output logic [NUM_INPUTS*LAG_WIDTH-1:0] auto_lag,
    output logic [NUM_INPUTS*LAG_WIDTH-1:0] cross_lag,
    output logic                            busy,
    output logic                            scan_wrap
);

    state_e               state_q;
    logic [LEN_WIDTH-1:0] tick_cnt_q;
    logic                 clear_q;
    logic                 enable_q;
    logic                 req_q;
    logic                 busy_q;
    logic                 wrap_q;
    logic [NUM_INPUTS-1:0] wrap_w;
    logic                 cfg_live_w;
    logic                 step_w;
    logic                 last_tick_w;

    assign cfg_live_w  = (state_q == ST_IDLE);
    assign step_w      = (state_q == ST_STEP);
    assign last_tick_w = tick && (tick_cnt_q == LEN_WIDTH'(1));

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_line
        logic                 we_w;
        logic [LAG_WIDTH-1:0] auto_w;
        logic [LAG_WIDTH-1:0] cross_w;

        assign we_w = cfg_load && (cfg_line == CFG_LINE_WIDTH'(i));

        lag_stepper #(
            .LAG_WIDTH (LAG_WIDTH),
            .MAX_AUTO  (MAX_LAG_AUTO),
            .MAX_CROSS (MAX_LAG_CROSS)
        ) u_stepper (
            .clk_i        (sysclk),
            .rst_ni       (reset_n),
            .cfg_we_i     (we_w),
            .cfg_live_i   (cfg_live_w),
            .auto_base_i  (auto_base),
            .cross_base_i (cross_base),
            .scan_auto_i  (scan_auto),
            .scan_cross_i (scan_cross),
            .step_i       (step_w),
            .auto_lag_o   (auto_w),
            .cross_lag_o  (cross_w),
            .wrap_o       (wrap_w[i])
        );

        assign auto_lag[lag_lsb(i, LAG_WIDTH) +: LAG_WIDTH]  = auto_w;
        assign cross_lag[lag_lsb(i, LAG_WIDTH) +: LAG_WIDTH] = cross_w;
    end

    // Sequencer FSM with registered outputs that follow the state being entered.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            clear_q    <= 1'b0;
            enable_q   <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            wrap_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CLEAR;
                        clear_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    tick_cnt_q <= (int_len == '0) ? LEN_WIDTH'(1) : int_len;
                    state_q    <= ST_INTEGRATE;
                    enable_q   <= 1'b1;
                end
                ST_INTEGRATE: begin
                    if (!start || last_tick_w) begin
                        state_q  <= ST_SNAP;
                        enable_q <= 1'b0;
                        req_q    <= 1'b1;
                    end else if (tick) begin
                        tick_cnt_q <= tick_cnt_q - 1'b1;
                    end
                end
                ST_SNAP: begin
                    if (snapshot_ack) begin
                        state_q <= ST_STEP;
                        req_q   <= 1'b0;
                    end
                end
                ST_STEP: begin
                    wrap_q <= |wrap_w;
                    if (start && continuous) begin
                        state_q <= ST_CLEAR;
                        clear_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    enable_q <= 1'b0;
                    req_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign counters_clear  = clear_q;
    assign counters_enable = enable_q;
    assign snapshot_req    = req_q;
    assign busy            = busy_q;
    assign scan_wrap       = wrap_q;

endmodule

// File: tb/tb_integration_scheduler.sv
// Self-checking bench for integration_scheduler: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_integration_scheduler;

    localparam int N    = 8;
    localparam int LW   = 12;
    localparam int LENW = 24;
    localparam int MA   = 4;
    localparam int MC   = 4;

    logic            sysclk = 1'b0;
    logic            reset_n = 1'b1;
    logic            tick = 1'b0;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic [LENW-1:0] int_len = '0;
    logic            cfg_load = 1'b0;
    logic [7:0]      cfg_line = '0;
    logic [LW-1:0]   auto_base = '0;
    logic [LW-1:0]   cross_base = '0;
    logic            scan_auto = 1'b0;
    logic            scan_cross = 1'b0;
    logic            snapshot_ack = 1'b0;
    logic            counters_clear;
    logic            counters_enable;
    logic            snapshot_req;
    logic [N*LW-1:0] auto_lag;
    logic [N*LW-1:0] cross_lag;
    logic            busy;
    logic            scan_wrap;

    integration_scheduler #(
        .NUM_INPUTS    (N),
        .LAG_WIDTH     (LW),
        .MAX_LAG_AUTO  (MA),
        .MAX_LAG_CROSS (MC),
        .LEN_WIDTH     (LENW)
    ) dut (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .tick            (tick),
        .start           (start),
        .continuous      (continuous),
        .int_len         (int_len),
        .cfg_load        (cfg_load),
        .cfg_line        (cfg_line),
        .auto_base       (auto_base),
        .cross_base      (cross_base),
        .scan_auto       (scan_auto),
        .scan_cross      (scan_cross),
        .snapshot_ack    (snapshot_ack),
        .counters_clear  (counters_clear),
        .counters_enable (counters_enable),
        .snapshot_req    (snapshot_req),
        .auto_lag        (auto_lag),
        .cross_lag       (cross_lag),
        .busy            (busy),
        .scan_wrap       (scan_wrap)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 clearing, 2 integrating, 3 awaiting ack, 4 stepping
    int m_phase = 0;
    int m_left = 0;
    int ph = 0;
    bit m_wrap = 0;
    int m_abase[N];
    int m_cbase[N];
    int m_alag[N];
    int m_clag[N];
    bit m_sa[N];
    bit m_sc[N];

    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_left = 0;
            m_wrap = 0;
            for (int l = 0; l < N; l++) begin
                m_abase[l] = 0; m_cbase[l] = 0;
                m_alag[l] = 0;  m_clag[l] = 0;
                m_sa[l] = 0;    m_sc[l] = 0;
            end
        end else begin
            ph = m_phase;
            m_wrap = 0;
            case (ph)
                0: if (start) m_phase = 1;
                1: begin
                    m_left = (int_len == 0) ? 1 : int'(int_len);
                    m_phase = 2;
                end
                2: begin
                    if (!start) m_phase = 3;
                    else if (tick) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = 3;
                    end
                end
                3: if (snapshot_ack) m_phase = 4;
                default: begin
                    for (int l = 0; l < N; l++) begin
                        if (m_sa[l]) begin
                            if (m_alag[l] + 1 >= MA) begin
                                m_alag[l] = m_abase[l]; m_wrap = 1;
                            end else m_alag[l] = m_alag[l] + 1;
                        end
                        if (m_sc[l]) begin
                            if (m_clag[l] + 1 >= MC) begin
                                m_clag[l] = m_cbase[l]; m_wrap = 1;
                            end else m_clag[l] = m_clag[l] + 1;
                        end
                    end
                    m_phase = (start && continuous) ? 1 : 0;
                end
            endcase
            if (cfg_load && int'(cfg_line) < N) begin
                m_abase[cfg_line] = (int'(auto_base) > MA - 1) ? MA - 1 : int'(auto_base);
                m_cbase[cfg_line] = (int'(cross_base) > MC - 1) ? MC - 1 : int'(cross_base);
                m_sa[cfg_line] = scan_auto;
                m_sc[cfg_line] = scan_cross;
                if (ph == 0) begin
                    m_alag[cfg_line] = m_abase[cfg_line];
                    m_clag[cfg_line] = m_cbase[cfg_line];
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [N*LW-1:0] ea, ec;
    always @(negedge sysclk) begin
        for (int l = 0; l < N; l++) begin
            ea[l*LW +: LW] = LW'(m_alag[l]);
            ec[l*LW +: LW] = LW'(m_clag[l]);
        end
        chk("clear", 128'(counters_clear), 128'(m_phase == 1));
        chk("enable", 128'(counters_enable), 128'(m_phase == 2));
        chk("req", 128'(snapshot_req), 128'(m_phase == 3));
        chk("busy", 128'(busy), 128'(m_phase != 0));
        chk("wrap", 128'(scan_wrap), 128'(m_wrap));
        chk("auto_lag", 128'(auto_lag), 128'(ea));
        chk("cross_lag", 128'(cross_lag), 128'(ec));
    end

    // ---------------- observation counters ----------------
    int n_clear = 0;
    int n_entick = 0;
    int n_wrap = 0;
    int clr_lag2[$];

    always @(posedge sysclk) if (counters_enable && tick) n_entick++;

    always @(negedge sysclk) begin
        if (counters_clear) begin
            n_clear++;
            clr_lag2.push_back(int'(auto_lag[2*LW +: LW]));
        end
        if (scan_wrap) n_wrap++;
    end

    // Tick strobe: one cycle high in every three.
    bit tick_auto = 0;
    initial begin
        int tp;
        tp = 0;
        forever begin
            @(negedge sysclk);
            if (tick_auto) begin
                tick = (tp == 2);
                tp = (tp + 1) % 3;
            end else begin
                tick = 1'b0;
                tp = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_req();
        int k;
        k = 0;
        while (!snapshot_req && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        chk("req_timeout", 128'(snapshot_req), 128'(1));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge sysclk);
            k++;
        end
        chk("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic ack_pulse();
        @(negedge sysclk);
        snapshot_ack = 1'b1;
        @(negedge sysclk);
        snapshot_ack = 1'b0;
    endtask

    task automatic cfg(input int line, input int ab, input int cb,
                       input bit sa, input bit sc);
        cfg_line = 8'(line);
        auto_base = LW'(ab);
        cross_base = LW'(cb);
        scan_auto = sa;
        scan_cross = sc;
        cfg_load = 1'b1;
        @(negedge sysclk);
        cfg_load = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int b_clr, b_tick, b_wrap, qb, k;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_auto", 128'(auto_lag), 128'(0));
        chk("rst_cross", 128'(cross_lag), 128'(0));
        reset_n = 1'b1;
        tick_auto = 1;
        repeat (2) @(negedge sysclk);

        // Single run, 5 ticks, no lag change.
        b_clr = n_clear; b_tick = n_entick;
        int_len = 24'd5; continuous = 1'b0; start = 1'b1;
        wait_req();
        start = 1'b0;
        chk("t1_clears", 128'(n_clear - b_clr), 128'(1));
        chk("t1_ticks", 128'(n_entick - b_tick), 128'(5));
        repeat (3) @(negedge sysclk);
        chk("t1_req_held", 128'(snapshot_req), 128'(1));
        ack_pulse();
        wait_idle();
        chk("t1_auto", 128'(auto_lag), 128'(0));

        // Auto scan on line 2, base 1, continuous runs.
        cfg(2, 1, 0, 1'b1, 1'b0);
        chk("t2_cfg_live", 128'(auto_lag[2*LW +: LW]), 128'(1));
        b_wrap = n_wrap; qb = clr_lag2.size();
        int_len = 24'd2; continuous = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_req();
            ack_pulse();
        end
        k = 0;
        while (clr_lag2.size() < qb + 4 && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        chk("t2_nclr", 128'(clr_lag2.size() - qb), 128'(4));
        if (clr_lag2.size() >= qb + 4) begin
            chk("t2_seq0", 128'(clr_lag2[qb]), 128'(1));
            chk("t2_seq1", 128'(clr_lag2[qb+1]), 128'(2));
            chk("t2_seq2", 128'(clr_lag2[qb+2]), 128'(3));
            chk("t2_seq3", 128'(clr_lag2[qb+3]), 128'(1));
        end
        start = 1'b0; continuous = 1'b0;
        wait_req();
        ack_pulse();
        wait_idle();
        chk("t2_wraps", 128'(n_wrap - b_wrap), 128'(1));
        chk("t2_auto", 128'(auto_lag), 128'(96'd2 << 24));
        chk("t2_cross", 128'(cross_lag), 128'(0));

        // int_len 0 integrates exactly one tick.
        b_tick = n_entick;
        int_len = '0; start = 1'b1;
        wait_req();
        start = 1'b0;
        chk("t3_ticks", 128'(n_entick - b_tick), 128'(1));
        ack_pulse();
        wait_idle();

        // Early stop after 2 of 10 ticks.
        b_tick = n_entick;
        int_len = 24'd10; start = 1'b1;
        k = 0;
        while (n_entick - b_tick < 2 && k < 100) begin
            @(negedge sysclk);
            k++;
        end
        start = 1'b0;
        @(negedge sysclk);
        chk("t4_req", 128'(snapshot_req), 128'(1));
        chk("t4_en", 128'(counters_enable), 128'(0));
        chk("t4_ticks", 128'(n_entick - b_tick), 128'(2));
        ack_pulse();
        wait_idle();

        // Config during integration: bases only, live offsets untouched.
        int_len = 24'd3; start = 1'b1;
        k = 0;
        while (!counters_enable && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        cfg(5, 0, 7, 1'b0, 1'b1);
        cfg(8, 3, 2, 1'b1, 1'b1);
        chk("t5_cross5_hold", 128'(cross_lag[5*LW +: LW]), 128'(0));
        wait_req();
        start = 1'b0;
        ack_pulse();
        wait_idle();
        chk("t5_cross5_step", 128'(cross_lag[5*LW +: LW]), 128'(1));
        chk("t5_auto7", 128'(auto_lag[7*LW +: LW]), 128'(0));
        cfg(6, 0, 9, 1'b0, 1'b0);
        chk("t5_clamp", 128'(cross_lag[6*LW +: LW]), 128'(3));

        // Reset in SNAP, then a normal run.
        int_len = 24'd1; start = 1'b1;
        wait_req();
        start = 1'b0;
        @(negedge sysclk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req_async", 128'(snapshot_req), 128'(0));
        chk("t6_busy_async", 128'(busy), 128'(0));
        chk("t6_auto_async", 128'(auto_lag), 128'(0));
        @(negedge sysclk);
        @(negedge sysclk);
        reset_n = 1'b1;
        ack_pulse();
        @(negedge sysclk);
        chk("t6_ack_ignored", 128'(busy), 128'(0));
        b_clr = n_clear;
        int_len = 24'd2; start = 1'b1;
        wait_req();
        start = 1'b0;
        ack_pulse();
        wait_idle();
        chk("t6_clears", 128'(n_clear - b_clr), 128'(1));

        tick_auto = 0;
        repeat (2) @(negedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/integration_scheduler.md
# integration_scheduler

Sequencer for the correlator counter bank. It owns the integration cycle: clear counters, integrate for a programmed number of sample ticks, freeze, hand a snapshot to the packet generator, then step per-line auto and cross lag offsets for lag scanning. It sits between the command parser and the counter/delay-line datapath, replacing free-running lag stepping on the packet clock.

## Interface

Parameters:
- NUM_INPUTS, 8, number of correlated inputs (lines × mux lines)
- LAG_WIDTH, 12, width of each lag offset
- MAX_LAG_AUTO, 1, exclusive upper bound for auto lag offset
- MAX_LAG_CROSS, 1, exclusive upper bound for cross lag offset
- LEN_WIDTH, 24, width of integration length (sample ticks)

Ports:
- sysclk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe per sample (smpclk edge resynchronised upstream)
- start  in  1  level; high requests integration
- continuous  in  1  1: re-arm after each snapshot while start high
- int_len  in  LEN_WIDTH  ticks per integration; 0 treated as 1
- cfg_load  in  1  one-cycle strobe: latch cfg_line/base/scan fields
- cfg_line  in  8  line index for cfg_load; ≥NUM_INPUTS ignored
- auto_base, cross_base  in  LAG_WIDTH  base offsets for cfg_line
- scan_auto, scan_cross  in  1  enable lag stepping for cfg_line
- snapshot_ack  in  1  packet generator has captured payload
- counters_clear  out  1  one-cycle clear pulse to all counters
- counters_enable  out  1  counters accumulate while high
- snapshot_req  out  1  high until snapshot_ack
- auto_lag, cross_lag  out  NUM_INPUTS*LAG_WIDTH  current offsets, line a at [a*LAG_WIDTH+:LAG_WIDTH]
- busy  out  1  state ≠ IDLE
- scan_wrap  out  1  one-cycle pulse when any scanning offset wraps

## Operation

- States: IDLE, CLEAR, INTEGRATE, SNAP, STEP.
- IDLE: outputs quiescent. start=1 → CLEAR.
- CLEAR: counters_clear=1 for exactly one cycle; load tick counter with max(int_len,1) (int_len sampled here, held for the run) → INTEGRATE.
- INTEGRATE: counters_enable=1; decrement on tick; on tick with count==1 → SNAP (enable drops the cycle after that tick). start falling → SNAP immediately (partial integration still delivered).
- SNAP: counters_enable=0, snapshot_req=1. On snapshot_ack → STEP. No timeout.
- STEP: one cycle. For each line with scan_auto: auto_lag ← auto_lag+1, or auto_base when result ≥ MAX_LAG_AUTO; same for cross with MAX_LAG_CROSS. Lines without scan keep offset. Any wrap → scan_wrap pulse. Next: CLEAR if start && continuous, else IDLE.
- cfg_load: writes base registers and scan flags for cfg_line, and sets that line's live offsets to the base, only in IDLE or STEP-free cycles of IDLE; cfg_load outside IDLE updates base/flags only, live offsets untouched until next wrap. Base ≥ max is clamped to max-1.
- Offsets change only in STEP or IDLE cfg_load, never while counters_enable=1.
- Width: all lag arithmetic LAG_WIDTH unsigned; compare before wrap to avoid overflow.

## Timing

- Reset (async assert, sync-release assumed upstream): state IDLE, all outputs 0, all offsets/bases 0, scan flags 0, tick counter 0.
- start→counters_clear: 1 cycle (IDLE cycle sees start, CLEAR next).
- counters_clear→counters_enable: 1 cycle; enable held exactly until int_len ticks counted.
- snapshot_req rises the cycle after last tick; ack in same cycle as req rise accepted next edge; ack while not in SNAP ignored.
- STEP→new offsets visible on outputs the cycle after STEP, same cycle as next CLEAR pulse.
- tick coincident with entry to INTEGRATE counts.
- start low in SNAP: still waits for ack, then STEP → IDLE.
- reset_n low mid-run: immediate IDLE, snapshot_req and counters_enable drop asynchronously.

## Structure

- Shared package: state encoding, LAG_WIDTH/LEN_WIDTH defaults, lag-field packing helper (line index → bit offset).
- Sub-module lag_stepper (one per line, generated): holds base, scan flag, live offset, computes next/wrap; scheduler FSM ORs wrap outputs.

## Test plan

- int_len=5, ticks every 3 cycles, start pulse held, continuous=0 → one clear, enable high across exactly 5 ticks, snapshot_req, ack after 4 cycles → IDLE, offsets unchanged.
- MAX_LAG_AUTO=4, line 2 scan_auto base 1, continuous=1 → auto_lag[2] sequence 1,2,3,1 across runs, scan_wrap on 3→1 only; other lines constant.
- int_len=0 → integrates exactly 1 tick.
- start dropped after 2 of 10 ticks → SNAP next cycle, after ack → IDLE.
- cfg_load during INTEGRATE with cross_base=7 → live cross_lag unchanged until wrap; cfg_line=NUM_INPUTS ignored; base ≥ MAX clamped.
- reset_n asserted in SNAP → all outputs 0 same cycle, later ack ignored, next start runs normally.
